exposure_sequencer: RTL

- Frame-level controller for the pixel array; drives its `erase`/`expose`/`convert`/`read`/`pixel_select` control inputs.
- Runs one frame per `start`: erase, programmable exposure, ADC ramp conversion, then pixel-by-pixel readout with valid/ready backpressure to the downstream consumer.
- Sits between the system/register interface and the pixel array, in place of the fixed-timing datapath controller.

---
 rtl/pixel_ctrl_pkg.sv | 26 ++
 rtl/phase_timer.sv | 38 +++
 rtl/exposure_sequencer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/pixel_ctrl_pkg.sv
// Shared types and helpers for the pixel-array frame sequencer.
// Optional feature macro used by the sequencer: EXPOSURE_SEQ_CONTINUOUS_EN.
package pixel_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ERASE   = 3'd1,
      EXPOSE  = 3'd2,
      CONVERT = 3'd3,
      READ    = 3'd4
   } seq_state_t;

   // Width of the shared phase timer: it must hold the longest phase load value.
   function automatic int timer_width(input int exp_w, input int cnt_w, input int erase_n);
      int w;
      w = exp_w;
      if (cnt_w + 1 > w) begin
         w = cnt_w + 1;
      end
      if ($clog2(erase_n + 1) > w) begin
         w = $clog2(erase_n + 1);
      end
      return w;
   endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter shared by all timed phases. Saturates at zero.
module phase_timer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] value,
   output logic             expired
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // Next count: load wins, otherwise count down and hold at zero.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = value;
      end else if (count_q != {WIDTH{1'b0}}) begin
         count_d = count_q - {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
         count_d = count_q;
      end
   end

   // Counter register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= {WIDTH{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign expired = (count_q == {WIDTH{1'b0}});

endmodule

// File: rtl/exposure_sequencer.sv
// Frame controller: erase, exposure, ADC ramp conversion, then pixel readout
// with valid/ready handshake. Optional macro EXPOSURE_SEQ_CONTINUOUS_EN lets
// `cont` chain frames back-to-back without a new `start`.
module exposure_sequencer
   import pixel_ctrl_pkg::*;
#(
   parameter int pixel_count   = 4,
   parameter int counter_width = 8,
   parameter int exp_width     = 16,
   parameter int erase_cycles  = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic [exp_width-1:0]           exposure_cycles,
   input  logic                           cont,
   output logic                           erase,
   output logic                           expose,
   output logic                           convert,
   output logic                           read,
   output logic [$clog2(pixel_count)-1:0] pixel_select,
   input  logic                           out_ready,
   output logic                           busy,
   output logic                           frame_done
);

   localparam int TW = timer_width(exp_width, counter_width, erase_cycles);
   localparam int PW = $clog2(pixel_count);
   localparam logic [TW-1:0] ERASE_LOAD = TW'(erase_cycles - 1);
   localparam logic [TW-1:0] CONV_LOAD  = TW'((2 ** counter_width) - 1);
   localparam logic [PW-1:0] LAST_PIX   = PW'(pixel_count - 1);

   seq_state_t          state_q, state_d;
   logic [exp_width-1:0] exp_q, exp_d;
   logic [PW-1:0]       pix_q, pix_d;
   logic                erase_q, erase_d, expose_q, expose_d;
   logic                convert_q, convert_d, read_q, read_d;
   logic                busy_q, busy_d, done_q, done_d;
   logic                tmr_load;
   logic [TW-1:0]       tmr_value;
   logic [TW-1:0]       exp_load;
   logic                tmr_expired;
   logic                accept;

   phase_timer #(.WIDTH(TW)) u_timer (
      .clk     (clk),
      .reset   (reset),
      .load    (tmr_load),
      .value   (tmr_value),
      .expired (tmr_expired)
   );

   assign accept = (state_q == READ) && out_ready;

`ifndef EXPOSURE_SEQ_CONTINUOUS_EN
   logic unused_cont;
   assign unused_cont = cont;
`endif

   // Exposure load value; a latched zero still gives one exposure cycle.
   always_comb begin
      if (exp_q == {exp_width{1'b0}}) begin
         exp_load = {TW{1'b0}};
      end else begin
         exp_load = TW'(exp_q) - TW'(1);
      end
   end

   // State register plus all registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         exp_q     <= {exp_width{1'b0}};
         pix_q     <= {PW{1'b0}};
         erase_q   <= 1'b0;
         expose_q  <= 1'b0;
         convert_q <= 1'b0;
         read_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         exp_q     <= exp_d;
         pix_q     <= pix_d;
         erase_q   <= erase_d;
         expose_q  <= expose_d;
         convert_q <= convert_d;
         read_q    <= read_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   // Next state, timer loads, exposure latch and readout counter.
   always_comb begin
      state_d   = state_q;
      exp_d     = exp_q;
      pix_d     = pix_q;
      done_d    = 1'b0;
      tmr_load  = 1'b0;
      tmr_value = {TW{1'b0}};
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = ERASE;
               exp_d     = exposure_cycles;
               tmr_load  = 1'b1;
               tmr_value = ERASE_LOAD;
            end else begin
               state_d = IDLE;
            end
         end
         ERASE: begin
            if (tmr_expired) begin
               state_d   = EXPOSE;
               tmr_load  = 1'b1;
               tmr_value = exp_load;
            end else begin
               state_d = ERASE;
            end
         end
         EXPOSE: begin
            if (tmr_expired) begin
               state_d   = CONVERT;
               tmr_load  = 1'b1;
               tmr_value = CONV_LOAD;
            end else begin
               state_d = EXPOSE;
            end
         end
         CONVERT: begin
            if (tmr_expired) begin
               state_d = READ;
               pix_d   = {PW{1'b0}};
            end else begin
               state_d = CONVERT;
            end
         end
         READ: begin
            if (accept) begin
               if (pix_q == LAST_PIX) begin
                  done_d  = 1'b1;
                  pix_d   = {PW{1'b0}};
                  state_d = IDLE;
`ifdef EXPOSURE_SEQ_CONTINUOUS_EN
                  if (cont) begin
                     state_d   = ERASE;
                     exp_d     = exposure_cycles;
                     tmr_load  = 1'b1;
                     tmr_value = ERASE_LOAD;
                  end else begin
                     state_d = IDLE;
                  end
`endif
               end else begin
                  pix_d = pix_q + PW'(1);
               end
            end else begin
               state_d = READ;
            end
         end
         default: begin
            state_d = IDLE;
            pix_d   = {PW{1'b0}};
         end
      endcase
   end

   // Control outputs decoded from the next state so they can be registered.
   always_comb begin
      erase_d   = 1'b0;
      expose_d  = 1'b0;
      convert_d = 1'b0;
      read_d    = 1'b0;
      busy_d    = (state_d != IDLE);
      case (state_d)
         ERASE:   erase_d   = 1'b1;
         EXPOSE:  expose_d  = 1'b1;
         CONVERT: convert_d = 1'b1;
         READ:    read_d    = 1'b1;
         default: busy_d    = 1'b0;
      endcase
   end

   assign erase        = erase_q;
   assign expose       = expose_q;
   assign convert      = convert_q;
   assign read         = read_q;
   assign pixel_select = pix_q;
   assign busy         = busy_q;
   assign frame_done   = done_q;

endmodule
